// File: rtl/dmem_responder.sv
// MEM-stage data memory responder: word-addressed SRAM model with WAIT_STATES wait states, pipeline stall and error flagging.
// Optional byte-enable writes are built when the macro DMEM_BYTE_WRITE_EN is defined.
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
`ifdef DMEM_BYTE_WRITE_EN
  input  logic [3:0]        req_be,
`endif
  output logic              stall,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned OFF_W = IDX_W + 2;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept_c;
  logic             enter_resp_c;

  logic             write_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             err_q;

  logic             req_c;
  logic [IDX_W-1:0] live_idx_c;
  logic             live_range_err_c;
  logic             live_align_err_c;
  logic             live_err_c;

  logic             in_idle_c;
  logic             cur_write_c;
  logic [IDX_W-1:0] cur_idx_c;
  logic [31:0]      cur_wdata_c;
  logic             cur_err_c;

  logic [31:0]      mem [DEPTH_WORDS];

`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]       be_q;
  logic [3:0]       cur_be_c;
`endif

  // Decode of the live request as seen in IDLE
  assign req_c            = req_read | req_write;
  assign live_idx_c       = req_addr[OFF_W-1:2];
  assign live_range_err_c = |(req_addr >> OFF_W);
  assign live_err_c       = live_range_err_c | live_align_err_c;

`ifdef DMEM_BYTE_WRITE_EN
  // Narrow writes relax alignment; reads and full/other masks stay word aligned
  always_comb begin
    live_align_err_c = (req_addr[1:0] != 2'b00);
    if (req_write) begin
      case (req_be)
        4'b0001, 4'b0010, 4'b0100, 4'b1000: live_align_err_c = 1'b0;
        4'b0011, 4'b1100:                   live_align_err_c = req_addr[0];
        default:                            ;
      endcase
    end
  end
`else
  assign live_align_err_c = (req_addr[1:0] != 2'b00);
`endif

  // With zero wait states the access completes on the accept edge, so use live inputs in IDLE
  assign in_idle_c   = (state_q == ST_IDLE);
  assign cur_write_c = in_idle_c ? req_write  : write_q;
  assign cur_idx_c   = in_idle_c ? live_idx_c : idx_q;
  assign cur_wdata_c = in_idle_c ? req_wdata  : wdata_q;
  assign cur_err_c   = in_idle_c ? live_err_c : err_q;
`ifdef DMEM_BYTE_WRITE_EN
  assign cur_be_c    = in_idle_c ? req_be     : be_q;
`endif

  // Next-state and wait counter
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          accept_c = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp_c = (state_d == ST_RESP) && (state_q != ST_RESP);

  // Stall is forced low while reset is asserted so a held request does not freeze the pipe
  assign stall = reset & ((in_idle_c & req_c) | (state_q == ST_WAIT));

  // Memory contents are intentionally not reset; writes happen only outside reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      write_q   <= 1'b0;
      idx_q     <= '0;
      wdata_q   <= '0;
      err_q     <= 1'b0;
`ifdef DMEM_BYTE_WRITE_EN
      be_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_valid <= enter_resp_c;
      if (accept_c) begin
        write_q <= req_write;
        idx_q   <= live_idx_c;
        wdata_q <= req_wdata;
        err_q   <= live_err_c;
`ifdef DMEM_BYTE_WRITE_EN
        be_q    <= req_be;
`endif
      end
      if (enter_resp_c) begin
        rsp_err <= cur_err_c;
        if (cur_err_c) begin
          rsp_rdata <= '0;
        end else if (cur_write_c) begin
`ifdef DMEM_BYTE_WRITE_EN
          for (int i = 0; i < 4; i++) begin
            if (cur_be_c[i]) mem[cur_idx_c][8*i +: 8] <= cur_wdata_c[8*i +: 8];
          end
`else
          mem[cur_idx_c] <= cur_wdata_c;
`endif
        end else begin
          rsp_rdata <= mem[cur_idx_c];
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder: one instance with 2 wait states, one with 0.
module tb_dmem_responder;

  logic        clk;
  logic        reset;

  logic        rd2, wr2, rd0, wr0;
  logic [31:0] addr2, wdata2, addr0, wdata0;
  logic        stall2, valid2, err2, stall0, valid0, err0;
  logic [31:0] rdata2, rdata0;
`ifdef DMEM_BYTE_WRITE_EN
  logic [3:0]  be2, be0, be_drive;
`endif

  int errors = 0;
  int checks = 0;

  logic [31:0] got_rdata;
  logic        got_err;
  int          got_nstall;
  int          got_vat;

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2), .ADDR_W(32)) u_ws2 (
    .clk(clk), .reset(reset),
    .req_read(rd2), .req_write(wr2), .req_addr(addr2), .req_wdata(wdata2),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be(be2),
`endif
    .stall(stall2), .rsp_valid(valid2), .rsp_rdata(rdata2), .rsp_err(err2)
  );

  dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0), .ADDR_W(32)) u_ws0 (
    .clk(clk), .reset(reset),
    .req_read(rd0), .req_write(wr0), .req_addr(addr0), .req_wdata(wdata0),
`ifdef DMEM_BYTE_WRITE_EN
    .req_be(be0),
`endif
    .stall(stall0), .rsp_valid(valid0), .rsp_rdata(rdata0), .rsp_err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_req(input int sel);
    if (sel == 2) begin rd2 = 1'b0; wr2 = 1'b0; end
    else          begin rd0 = 1'b0; wr0 = 1'b0; end
  endtask

  // Issue one access and follow it until rsp_valid, counting stall cycles (bounded)
  task automatic access(input int sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    if (sel == 2) begin
      rd2 = r; wr2 = w; addr2 = a; wdata2 = d;
`ifdef DMEM_BYTE_WRITE_EN
      be2 = be_drive;
`endif
    end else begin
      rd0 = r; wr0 = w; addr0 = a; wdata0 = d;
`ifdef DMEM_BYTE_WRITE_EN
      be0 = be_drive;
`endif
    end
    got_nstall = 0;
    got_vat    = -1;
    got_rdata  = 32'hFFFF_FFFF;
    got_err    = 1'bx;
    for (int c = 1; c <= 20; c++) begin
      #1;
      if ((sel == 2) ? valid2 : valid0) begin
        got_vat   = c;
        got_rdata = (sel == 2) ? rdata2 : rdata0;
        got_err   = (sel == 2) ? err2 : err0;
        clear_req(sel);
        break;
      end
      if ((sel == 2) ? stall2 : stall0) got_nstall++;
      @(negedge clk);
    end
    if (got_vat < 0) clear_req(sel);
  endtask

  initial begin
    rd2 = 1'b0; wr2 = 1'b0; addr2 = '0; wdata2 = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
`ifdef DMEM_BYTE_WRITE_EN
    be2 = 4'hF; be0 = 4'hF; be_drive = 4'hF;
`endif
    reset = 1'b1;
    #2 reset = 1'b0;

    // Reset held with a read request pending
    rd2 = 1'b1; addr2 = 32'h10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("rst_stall", 32'(stall2), 32'd0);
      chk("rst_valid", 32'(valid2), 32'd0);
      chk("rst_rdata", rdata2, 32'd0);
      chk("rst_err",   32'(err2), 32'd0);
    end
    @(negedge clk);
    rd2 = 1'b0;
    reset = 1'b1;

    // Write then read with two wait states
    access(2, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF);
    chk("wr10_stall", 32'(got_nstall), 32'd3);
    chk("wr10_vat",   32'(got_vat), 32'd4);
    chk("wr10_err",   32'(got_err), 32'd0);
    access(2, 1'b1, 1'b0, 32'h10, 32'h0);
    chk("rd10_data",  got_rdata, 32'hDEAD_BEEF);
    chk("rd10_vat",   32'(got_vat), 32'd4);
    chk("rd10_err",   32'(got_err), 32'd0);

    // Response fields hold while idle
    @(negedge clk); #1;
    chk("hold_valid", 32'(valid2), 32'd0);
    chk("hold_stall", 32'(stall2), 32'd0);
    chk("hold_rdata", rdata2, 32'hDEAD_BEEF);

    // Zero wait states, back-to-back accesses
    access(0, 1'b0, 1'b1, 32'h0, 32'h11);
    chk("ws0_wr0_vat", 32'(got_vat), 32'd2);
    access(0, 1'b0, 1'b1, 32'h4, 32'h22);
    chk("ws0_wr4_vat", 32'(got_vat), 32'd2);
    access(0, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("ws0_rd0_data",  got_rdata, 32'h11);
    chk("ws0_rd0_vat",   32'(got_vat), 32'd2);
    chk("ws0_rd0_stall", 32'(got_nstall), 32'd1);
    access(0, 1'b1, 1'b0, 32'h4, 32'h0);
    chk("ws0_rd4_data",  got_rdata, 32'h22);
    chk("ws0_rd4_vat",   32'(got_vat), 32'd2);
    chk("ws0_rd4_stall", 32'(got_nstall), 32'd1);

    // Misaligned read
    access(2, 1'b1, 1'b0, 32'h6, 32'h0);
    chk("rd6_err",  32'(got_err), 32'd1);
    chk("rd6_data", got_rdata, 32'd0);
    chk("rd6_vat",  32'(got_vat), 32'd4);

    // Out-of-range write must not alias onto word 0
    access(2, 1'b0, 1'b1, 32'h0, 32'h5555_AAAA);
    access(2, 1'b0, 1'b1, 32'h400, 32'hFFFF_FFFF);
    chk("wr400_err", 32'(got_err), 32'd1);
    access(2, 1'b1, 1'b0, 32'h0, 32'h0);
    chk("rd0_data", got_rdata, 32'h5555_AAAA);
    chk("rd0_err",  32'(got_err), 32'd0);

    // Read+write together acts as a write; last word is in range
    access(2, 1'b1, 1'b1, 32'h3FC, 32'h0BAD_F00D);
    chk("rw3fc_err", 32'(got_err), 32'd0);
    access(2, 1'b1, 1'b0, 32'h3FC, 32'h0);
    chk("rd3fc_data", got_rdata, 32'h0BAD_F00D);
    chk("rd3fc_err",  32'(got_err), 32'd0);
    access(2, 1'b1, 1'b0, 32'h8000_0010, 32'h0);
    chk("rdhigh_err", 32'(got_err), 32'd1);

    // Reset during WAIT aborts the write
    access(2, 1'b0, 1'b1, 32'h8, 32'h1111_2222);
    chk("wr8_err", 32'(got_err), 32'd0);
    @(negedge clk);
    wr2 = 1'b1; addr2 = 32'h8; wdata2 = 32'h0000_CAFE;
    @(negedge clk); #1;
    chk("mid_wait_stall", 32'(stall2), 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall2), 32'd0);
    chk("mid_rst_valid", 32'(valid2), 32'd0);
    wr2 = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;
    chk("post_rst_stall", 32'(stall2), 32'd0);
    chk("post_rst_valid", 32'(valid2), 32'd0);
    chk("post_rst_rdata", rdata2, 32'd0);
    access(2, 1'b1, 1'b0, 32'h8, 32'h0);
    chk("rd8_data", got_rdata, 32'h1111_2222);
    chk("rd8_vat",  32'(got_vat), 32'd4);

`ifdef DMEM_BYTE_WRITE_EN
    // Byte-lane writes
    be_drive = 4'b1111;
    access(2, 1'b0, 1'b1, 32'h20, 32'h1234_5678);
    be_drive = 4'b0010;
    access(2, 1'b0, 1'b1, 32'h20, 32'h0000_AB00);
    chk("be_byte_err", 32'(got_err), 32'd0);
    be_drive = 4'b0000;
    access(2, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("be_rd_data", got_rdata, 32'h1234_AB78);
    access(2, 1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF);
    chk("be_none_err", 32'(got_err), 32'd0);
    access(2, 1'b1, 1'b0, 32'h20, 32'h0);
    chk("be_none_data", got_rdata, 32'h1234_AB78);
    be_drive = 4'b0011;
    access(2, 1'b0, 1'b1, 32'h21, 32'hFFFF_FFFF);
    chk("be_half_err", 32'(got_err), 32'd1);
    be_drive = 4'b1111;
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the pipeline's MEM-stage data access (address / write data / read / write strobe).
- Replaces the zero-latency data array with a word-addressed SRAM model that has a configurable wait-state count.
- Asserts a stall toward the pipeline until each access completes.
- Flags misaligned and out-of-range accesses instead of performing them.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; must be a power of two, at least 2.
- WAIT_STATES, 2: extra cycles between accept and completion; range 0..15.
- ADDR_W, 32: width of the byte address from the pipeline.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- req_read  in  1  load request from MEM stage
- req_write  in  1  store request from MEM stage
- req_addr  in  ADDR_W  byte address (ALU result)
- req_wdata  in  32  store data
- stall  out  1  freeze pipeline; access not yet complete
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  load data, valid when rsp_valid=1
- rsp_err  out  1  access rejected, valid when rsp_valid=1

Behaviour:
- Request present: req = req_read | req_write.
- Both req_read and req_write high: treat as a write. This is a legal combination, not an error.
- Reset values: state=IDLE, wait counter=0, stall=0, rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Reset does not clear memory contents.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if req, latch addr/wdata/write flag. Go to WAIT with counter=WAIT_STATES-1, or go directly to RESP if WAIT_STATES=0.
  - WAIT: decrement the counter; at 0, go to RESP.
  - RESP: go to IDLE.
- The array access is performed on the clock edge entering RESP.
  - Write: array[word] <= wdata.
  - Read: rsp_rdata <= array[word].
- Word index = req_addr[log2(DEPTH_WORDS)+1:2].
- Error: req_addr[1:0]!=0, or req_addr >= 4*DEPTH_WORDS.
  - No array write on error.
  - rsp_rdata=0, rsp_err=1 in RESP.
- stall = (IDLE & req) | WAIT.
- In RESP: stall=0, rsp_valid=1. The pipeline advances on that edge.
- Latency: request sampled at edge T; rsp_valid high during cycle T+WAIT_STATES+1.
- rsp_rdata and rsp_err hold their values after RESP until the next completion.
- The initiator holds request signals stable while stall=1. The responder uses latched copies regardless.
- A request present in the cycle after RESP is a new access. Back-to-back costs WAIT_STATES+2 cycles per access.
- No request in IDLE: stall=0, no state change.
- Reset asserted in WAIT: abort, no array write, return to IDLE. The pipeline re-issues the request after reset.
- Reset asserted in RESP: the write already committed on entry stays committed.
- Address wrap is not supported; out-of-range addresses always error.

Optional Feature:
- Macro: DMEM_BYTE_WRITE_EN.
- When defined:
  - Adds input port req_be[3:0] (byte enables, bit i selects bits 8i+7:8i).
  - Writes update only the enabled bytes.
  - req_be=0000 with req_write completes normally with no change.
  - Reads ignore req_be and return the full word.
  - Alignment check relaxes: half-word (be=0011 or 1100) requires addr[0]=0; single byte allows any addr[1:0]. In that case the word index still uses addr[..:2].
- When undefined: no req_be port; every write is a full word; strict word alignment.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_read=1 -> stall=0, rsp_valid=0, rsp_rdata=0, rsp_err=0 throughout.
- Write then read, WAIT_STATES=2:
  - Write 0xDEADBEEF to addr 0x10 -> stall high for 3 cycles, rsp_valid at cycle 4, rsp_err=0.
  - Then read 0x10 -> rsp_rdata=0xDEADBEEF at cycle 4.
- WAIT_STATES=0: back-to-back reads of 0x0 and 0x4 (preloaded 0x11, 0x22) -> each completes in 2 cycles with rdata 0x11, then 0x22; stall high exactly 1 cycle each.
- Errors:
  - Read addr 0x6 -> rsp_err=1, rdata=0.
  - Write 0x400 with DEPTH_WORDS=256 -> rsp_err=1; a subsequent read of 0x0 shows an unchanged value.
- Mid-access reset: write 0xCAFE to 0x8, assert reset in the WAIT cycle -> FSM returns to IDLE, stall=0; a later read of 0x8 returns the prior value.
- DMEM_BYTE_WRITE_EN: word 0x20 = 0x12345678; write be=0010, wdata=0x0000AB00 -> read returns 0x1234AB78. Half write be=0011 at addr 0x21 -> rsp_err=1.
